// File: rtl/adder_operand_recover.sv
// Recovers operand B = S - A from an adder result S and known operand A,
// using a SLICE-bit ripple-borrow subtractor iterated over WIDTH/SLICE cycles.
module adder_operand_recover #(
    parameter int WIDTH = 12,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             err
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   s_q, s_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             err_q, err_d;

    int unsigned      base;
    logic [SLICE-1:0] s_slice;
    logic [SLICE-1:0] a_slice;
    logic [SLICE:0]   slice_diff;
    logic             top_d;
    logic             top_bo;
    logic             last_slice;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        s_d        = s_q;
        a_d        = a_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        borrow_d   = borrow_q;
        err_d      = err_q;

        base       = int'(cnt_q) * SLICE;
        s_slice    = s_q[base +: SLICE];
        a_slice    = a_q[base +: SLICE];
        slice_diff = {1'b0, s_slice} - {1'b0, a_slice} - {{SLICE{1'b0}}, borrow_q};
        last_slice = (cnt_q == CNT_W'(NSLICE - 1));

        // Carry bit of S minus the final borrow: any nonzero difference or borrow means S - A is out of range.
        top_d      = s_q[WIDTH] ^ slice_diff[SLICE];
        top_bo     = ~s_q[WIDTH] & slice_diff[SLICE];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d      = sum_in;
                    a_d      = a_in;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                diff_d[base +: SLICE] = slice_diff[SLICE-1:0];
                borrow_d              = slice_diff[SLICE];
                cnt_d                 = cnt_q + CNT_W'(1);
                if (last_slice) begin
                    err_d   = top_d | top_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            a_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            a_q      <= a_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign b_out     = diff_q;
    assign err       = err_q;

endmodule

// File: doc/adder_operand_recover.md
ADDER_OPERAND_RECOVER -- requirements
Module: adder_operand_recover

Interface
REQ-001: Parameter WIDTH, default 12, operand width; sum width is WIDTH+1.
REQ-002: Parameter SLICE, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE (12/4 gives 3 slices).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset; assertion resets immediately, deassertion is synchronous to clk.
REQ-005: in_valid  input  1  request present.
REQ-006: in_ready  output  1  block can accept a request.
REQ-007: sum_in  input  WIDTH+1  13-bit adder result S.
REQ-008: a_in  input  WIDTH  known operand A.
REQ-009: out_valid  output  1  result present.
REQ-010: out_ready  input  1  consumer accepts the result.
REQ-011: b_out  output  WIDTH  recovered operand B = (S - A) mod 2^WIDTH.
REQ-012: err  output  1  S - A is outside 0..2^WIDTH-1, so S was not a legal sum with operand A.

Function
REQ-013: FSM states are IDLE, SUB and DONE; the encoding is free.
REQ-014: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015: IDLE with in_valid=1 SHALL capture sum_in and a_in, clear the slice counter and borrow, and go to SUB at that edge (the accept edge).
REQ-016: Each SUB cycle SHALL compute one SLICE-bit ripple-borrow difference, LSB slice first; borrow-in to slice 0 is 0; borrow-out is registered and feeds the next slice.
REQ-017: On the last slice edge, the FSM SHALL compute d12 = S[12] - final borrow as a 1-bit difference with borrow-out bo; it SHALL set err = d12 | bo and go to DONE.
REQ-018: Latency: out_valid SHALL rise exactly WIDTH/SLICE edges after the accept edge (3 for defaults).
REQ-019: b_out and err SHALL hold stable throughout DONE, regardless of sum_in/a_in changes.
REQ-020: In DONE with out_ready=1, the FSM SHALL return to IDLE at that edge; no new request is accepted on that same edge.
REQ-021: In DONE with out_ready=0, the FSM SHALL remain in DONE indefinitely.
REQ-022: Input changes during SUB SHALL have no effect, because operands are used only from the capture registers.
REQ-023: out_ready asserted outside DONE SHALL be ignored.
REQ-024: Throughput: at most one request per WIDTH/SLICE+2 cycles (5 for defaults).

Reset
REQ-025: rst_n=0 SHALL force state to IDLE, in_ready=1, out_valid=0, b_out=0, err=0, and clear the slice counter, borrow and capture registers.
REQ-026: Reset asserted during SUB or DONE SHALL abort the operation; no out_valid pulse SHALL follow the reset release.
REQ-027: First accept is possible on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-028: Accept S=0x0ABC, A=0x123; out_ready=1 -> out_valid rises 3 edges later with b_out=0x999, err=0, and the FSM is in IDLE the next cycle.
REQ-029: Accept S=0x1FFE, A=0xFFF -> b_out=0xFFF, err=0; S=0x0000, A=0x001 -> b_out=0xFFF, err=1 (negative); S=0x1000, A=0x000 -> b_out=0x000, err=1 (overflow).
REQ-030: Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, b_out and err are stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-031: Toggle sum_in/a_in randomly during SUB -> the result matches the operands captured at the accept edge.
REQ-032: Assert rst_n=0 mid-SUB (after slice 1) -> outputs are at reset values immediately (asynchronously); after release, in_ready=1 and no spurious out_valid appears.
REQ-033: Random sweep of 10k (A, B) pairs, with S = A + B from a reference adder model -> b_out=B and err=0 for every pair; random illegal S with S < A -> err=1.
